// File: rtl/xeng_pkg.sv
// Shared X-engine definitions: index-width helper, bank release state encoding
// and the default sample width.
package xeng_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FULL    = 2'd1,
    BANK_READING = 2'd2
  } bank_state_e;

  function automatic int log2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ant_buf_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old word.
module ant_buf_ram import xeng_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ant_pair_buf.sv
// Double-banked antenna sample buffer feeding baseline sample pairs to the CMAC.
// Optional saturating overflow event counter on output ovf_count: ANT_PAIR_BUF_OVF_CNT_EN.
//
// Bank release FSM (one per bank):
//   state        | meaning
//   BANK_EMPTY   | free for the writer
//   BANK_FULL    | window complete, not yet read
//   BANK_READING | being read; released by the first read of the other bank
module ant_pair_buf import xeng_pkg::*; #(
  parameter  int N_ANTS   = 16,
  parameter  int DATA_W   = DATA_W_DEF,
  localparam int ANT_BITS = log2_f(N_ANTS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   din,
  input  logic                din_valid,
  input  logic                din_sync,
  input  logic                en,
  input  logic [ANT_BITS-1:0] ant_a,
  input  logic [ANT_BITS-1:0] ant_b,
  input  logic                buf_sel,
  input  logic                last_triangle,
  output logic [DATA_W-1:0]   dout_a,
  output logic [DATA_W-1:0]   dout_b,
  output logic                dout_valid,
  output logic                dout_last_triangle,
  output logic [1:0]          bank_ready,
  output logic                overflow
`ifdef ANT_PAIR_BUF_OVF_CNT_EN
  ,
  output logic [15:0]         ovf_count
`endif
);

  localparam int ADDR_W = ANT_BITS + 1;

  logic [ANT_BITS-1:0] wr_idx_q, wr_idx_d, wr_slot;
  logic                wr_bank_q, wr_bank_d;
  logic                wr_wrap;
  logic                ovf_event;
  logic                overflow_q, overflow_d;
  bank_state_e         bank_st_q [2];
  bank_state_e         bank_st_d [2];

  logic                rd_vld_q, rd_vld_d;
  logic                rd_lt_q, rd_lt_d;
  logic [DATA_W-1:0]   ram_a, ram_b;
  logic [DATA_W-1:0]   dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic                dout_valid_q, dout_valid_d;
  logic                dout_lt_q, dout_lt_d;

  // Sync forces this cycle's sample to slot 0, so a sync can never complete a window.
  always_comb begin
    wr_slot    = din_sync ? '0 : wr_idx_q;
    wr_wrap    = din_valid && (wr_slot == ANT_BITS'(N_ANTS - 1));
    ovf_event  = din_valid && (wr_slot == '0) && (bank_st_q[wr_bank_q] != BANK_EMPTY);
    wr_idx_d   = wr_idx_q;
    wr_bank_d  = wr_bank_q;
    overflow_d = overflow_q | ovf_event;
    if (din_valid) begin
      wr_idx_d = wr_slot + ANT_BITS'(1);
      if (wr_wrap) wr_bank_d = ~wr_bank_q;
    end else if (din_sync) begin
      wr_idx_d = '0;
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      bank_st_d[k] = bank_st_q[k];
      case (bank_st_q[k])
        BANK_EMPTY:   if (wr_wrap && (wr_bank_q == 1'(k)))  bank_st_d[k] = BANK_FULL;
        BANK_FULL:    if (en && (buf_sel == 1'(k)))         bank_st_d[k] = BANK_READING;
        BANK_READING: if (en && (buf_sel != 1'(k)))         bank_st_d[k] = BANK_EMPTY;
        default:                                            bank_st_d[k] = BANK_EMPTY;
      endcase
    end
  end

  always_comb begin
    rd_vld_d     = en;
    rd_lt_d      = en & last_triangle;
    dout_valid_d = rd_vld_q;
    dout_lt_d    = rd_vld_q & rd_lt_q;
    dout_a_d     = rd_vld_q ? ram_a : dout_a_q;
    dout_b_d     = rd_vld_q ? ram_b : dout_b_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx_q     <= '0;
      wr_bank_q    <= 1'b0;
      overflow_q   <= 1'b0;
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      rd_vld_q     <= 1'b0;
      rd_lt_q      <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_lt_q    <= 1'b0;
      dout_a_q     <= '0;
      dout_b_q     <= '0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      wr_bank_q    <= wr_bank_d;
      overflow_q   <= overflow_d;
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      rd_vld_q     <= rd_vld_d;
      rd_lt_q      <= rd_lt_d;
      dout_valid_q <= dout_valid_d;
      dout_lt_q    <= dout_lt_d;
      dout_a_q     <= dout_a_d;
      dout_b_q     <= dout_b_d;
    end
  end

  // Two RAM copies share the write so both antennas of a baseline read in one cycle.
  ant_buf_ram #(.DATA_W(DATA_W), .DEPTH(2 * N_ANTS), .ADDR_W(ADDR_W)) u_ram_a (
    .clk     (clk),
    .wr_en   (din_valid),
    .wr_addr ({wr_bank_q, wr_slot}),
    .wr_data (din),
    .rd_en   (en),
    .rd_addr ({buf_sel, ant_a}),
    .rd_data (ram_a)
  );

  ant_buf_ram #(.DATA_W(DATA_W), .DEPTH(2 * N_ANTS), .ADDR_W(ADDR_W)) u_ram_b (
    .clk     (clk),
    .wr_en   (din_valid),
    .wr_addr ({wr_bank_q, wr_slot}),
    .wr_data (din),
    .rd_en   (en),
    .rd_addr ({buf_sel, ant_b}),
    .rd_data (ram_b)
  );

`ifdef ANT_PAIR_BUF_OVF_CNT_EN
  logic [15:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_event && (ovf_count_q != 16'hFFFF)) ovf_count_d = ovf_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_count_q <= '0;
    else        ovf_count_q <= ovf_count_d;
  end

  assign ovf_count = ovf_count_q;
`endif

  assign dout_a             = dout_a_q;
  assign dout_b             = dout_b_q;
  assign dout_valid         = dout_valid_q;
  assign dout_last_triangle = dout_lt_q;
  assign bank_ready         = {bank_st_q[1] != BANK_EMPTY, bank_st_q[0] != BANK_EMPTY};
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_ant_pair_buf.sv
// Scoreboard bench for ant_pair_buf: a window/bank model predicts each read pair,
// a negedge monitor pops and compares whenever dout_valid is presented.
module tb_ant_pair_buf;
  localparam int N  = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0, din_sync = 1'b0, en = 1'b0;
  logic [3:0]    ant_a = '0, ant_b = '0;
  logic          buf_sel = 1'b0, last_triangle = 1'b0;
  logic [DW-1:0] dout_a, dout_b;
  logic          dout_valid, dout_last_triangle, overflow;
  logic [1:0]    bank_ready;
`ifdef ANT_PAIR_BUF_OVF_CNT_EN
  logic [15:0]   ovf_count;
`endif

  always #5 clk = ~clk;

  ant_pair_buf #(.N_ANTS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_sync(din_sync),
    .en(en), .ant_a(ant_a), .ant_b(ant_b), .buf_sel(buf_sel), .last_triangle(last_triangle),
    .dout_a(dout_a), .dout_b(dout_b), .dout_valid(dout_valid),
    .dout_last_triangle(dout_last_triangle), .bank_ready(bank_ready), .overflow(overflow)
`ifdef ANT_PAIR_BUF_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          lt;
    bit          ka;
    bit          kb;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Reference model: stored windows, writer position, per-bank lifecycle
  // (0 = free, 1 = complete and unread, 2 = being read), overflow bookkeeping.
  logic [15:0] m_mem [2][N];
  bit          m_known [2][N];
  int          m_st [2];
  int          m_idx = 0;
  int          m_bank = 0;
  bit          m_ovf = 0;
  int          m_cnt = 0;
  logic [15:0] last_a = '0, last_b = '0;
  bit          last_k = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_st[0] = 0; m_st[1] = 0;
    m_idx = 0; m_bank = 0; m_ovf = 0; m_cnt = 0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) m_known[k][i] = 1'b0;
    last_a = '0; last_b = '0; last_k = 1'b1;
  endtask

  task automatic step(input bit v, input logic [15:0] d, input bit sync, input bit e,
                      input int a, input int b, input bit sel, input bit lt);
    exp_t x;
    int   slot;
    int   pre [2];
    bit   wrap;
    int   wrap_bank;
    din_valid = v; din = d; din_sync = sync; en = e;
    ant_a = 4'(a); ant_b = 4'(b); buf_sel = sel; last_triangle = lt;
    if (e) begin
      x.a = m_mem[sel][a]; x.ka = m_known[sel][a];
      x.b = m_mem[sel][b]; x.kb = m_known[sel][b];
      x.lt = lt; x.cyc = cyc + 2;
      exp_q.push_back(x);
    end
    pre = m_st;
    wrap = 0; wrap_bank = 0;
    if (v) begin
      slot = sync ? 0 : m_idx;
      if (slot == 0 && pre[m_bank] != 0) begin
        m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
      m_mem[m_bank][slot] = d;
      m_known[m_bank][slot] = 1'b1;
      if (slot == N - 1) begin
        wrap = 1; wrap_bank = m_bank; m_bank ^= 1; m_idx = 0;
      end else begin
        m_idx = slot + 1;
      end
    end else if (sync) begin
      m_idx = 0;
    end
    for (int k = 0; k < 2; k++) begin
      if (pre[k] == 0 && wrap && wrap_bank == k) m_st[k] = 1;
      else if (pre[k] == 1 && e && int'(sel) == k) m_st[k] = 2;
      else if (pre[k] == 2 && e && int'(sel) != k) m_st[k] = 0;
    end
    @(posedge clk); #1;
    chk("bank_ready", 32'(bank_ready), {30'd0, m_st[1] != 0, m_st[0] != 0});
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef ANT_PAIR_BUF_OVF_CNT_EN
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
  endtask

  task automatic idle();
    step(0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input logic [15:0] d);
    step(1, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a, input int b, input bit sel);
    step(0, '0, 0, 1, a, b, sel, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din_valid = 0; din_sync = 0; en = 0; last_triangle = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_a", 32'(dout_a), 32'd0);
    chk("rst_dout_b", 32'(dout_b), 32'd0);
    chk("rst_dout_last_triangle", 32'(dout_last_triangle), 32'd0);
    chk("rst_bank_ready", 32'(bank_ready), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
`ifdef ANT_PAIR_BUF_OVF_CNT_EN
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (rst_n) begin
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_valid: got dout_valid=1, expected 0 (cycle %0d)", cyc);
        end else begin
          x = exp_q.pop_front();
          chk("latency", 32'(cyc), 32'(x.cyc));
          if (x.ka) chk("dout_a", 32'(dout_a), 32'(x.a));
          if (x.kb) chk("dout_b", 32'(dout_b), 32'(x.b));
          chk("dout_last_triangle", 32'(dout_last_triangle), 32'(x.lt));
          last_a = x.a; last_b = x.b; last_k = x.ka && x.kb;
        end
      end else begin
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          x = exp_q.pop_front();
          n_tests++; n_fail++;
          $display("FAIL missing_valid: got dout_valid=0, expected 1 (cycle %0d)", cyc);
        end
        if (last_k) begin
          chk("hold_a", 32'(dout_a), 32'(last_a));
          chk("hold_b", 32'(dout_b), 32'(last_b));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    do_reset();
    idle();

    // Fill bank 0 with 0x100+idx, then read (8,0).
    for (int i = 0; i < N; i++) wr(16'h100 + 16'(i));
    chk("fill0_bank_ready", 32'(bank_ready), 32'd1);
    rd(8, 0, 0);
    idle(); idle();

    // Generator sweep over bank 0 while bank 1 is filled in the background.
    wcount = 0;
    for (int a = 0; a < N; a++)
      for (int b = a; b < N; b++) begin
        if (wcount < N && ((a * N + b) % 7 == 0)) begin
          step(1, 16'($urandom), 0, 1, a, b, 0, 1'($urandom_range(0, 1)));
          wcount++;
        end else begin
          step(0, '0, 0, 1, a, b, 0, 1'($urandom_range(0, 1)));
        end
      end
    while (wcount < N) begin wr(16'($urandom)); wcount++; end
    rd(3, 12, 1);
    chk("release_bank0", 32'(bank_ready[0]), 32'd0);
    idle(); idle();

    // Sync mid-window into bank 0.
    for (int i = 0; i < 7; i++) wr(16'h200 + 16'(i));
    step(1, 16'h2F0, 1, 0, 0, 0, 0, 0);
    chk("sync_no_ready", 32'(bank_ready[0]), 32'd0);
    for (int i = 1; i < N; i++) wr(16'h200 + 16'(i));
    chk("sync_refill_ready", 32'(bank_ready[0]), 32'd1);
    rd(0, 7, 0);
    rd(15, 1, 0);
    idle(); idle();

    // Same-cycle read/write of bank 1 slot 3 returns the old word.
    do_reset();
    for (int i = 0; i < N; i++) wr(16'(i));
    for (int i = 0; i < 3; i++) wr(16'(i));
    wr(16'hAAAA);
    step(1, 16'h0, 1, 0, 0, 0, 0, 0);
    wr(16'h1); wr(16'h2);
    step(1, 16'hBBBB, 0, 1, 3, 3, 1, 0);
    rd(3, 3, 1);
    for (int i = 4; i < N; i++) wr(16'(i));
    idle(); idle();

    // Reset while output valid, bank 1 full and a read in flight.
    chk("pre_rst_bank1_full", 32'(bank_ready[1]), 32'd1);
    rd(1, 2, 0);
    rd(4, 5, 0);
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) idle();

    // Twenty windows with no reads.
    do_reset();
    for (int w = 1; w <= 20; w++)
      for (int i = 0; i < N; i++) begin
        if (w == 3 && i == 0) chk("ovf_before_w3", 32'(overflow), 32'd0);
        wr(16'($urandom));
        if (w == 3 && i == 0) chk("ovf_at_w3", 32'(overflow), 32'd1);
      end
`ifdef ANT_PAIR_BUF_OVF_CNT_EN
    chk("ovf_count_20w", 32'(ovf_count), 32'd18);
`endif

    // Random mix of writes, syncs and reads.
    do_reset();
    for (int n = 0; n < 1500; n++)
      step(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) idle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
